// File: rtl/stage12_rnd_sat.sv
// -----------------------------------------------------------------------------
// stage12_rnd_sat
//
// Round-and-saturate stage between the stage-1 twiddle multiplier and the
// stage-2 shift-register/butterfly of the 16-lane parallel FFT. Narrows the
// four 16-lane complex streams (sum re/im, diff re/im) from IN_WIDTH back to
// OUT_WIDTH. It also tracks the beat position inside a frame of
// BEATS_PER_FRAME valid beats and reports per-beat and per-frame clipping.
//
// Ports
//   clk              rising-edge clock
//   rstn             asynchronous active-low reset
//   twd_01_*         16 lanes x IN_WIDTH, lane i at bits [i*IN_WIDTH +: IN_WIDTH]
//   shift_02_valid   input beat valid (all 64 words sampled together)
//   stg02_*          16 lanes x OUT_WIDTH, lane i at bits [i*OUT_WIDTH +: OUT_WIDTH]
//   shift_03_valid   output beat valid, 2 cycles after shift_02_valid
//   frame_start      output beat is frame index 0
//   frame_end        output beat is frame index BEATS_PER_FRAME-1
//   sat_beat         any of the 64 words of the output beat clipped
//   frame_sat_cnt    clipped-beat count of the last completed frame
// -----------------------------------------------------------------------------
module stage12_rnd_sat #(
    parameter int IN_WIDTH        = 13,
    parameter int OUT_WIDTH       = 11,
    parameter int FRAC_DROP       = 1,
    parameter int BEATS_PER_FRAME = 32
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic [16*IN_WIDTH-1:0]                 twd_01_sum_re,
    input  logic [16*IN_WIDTH-1:0]                 twd_01_sum_im,
    input  logic [16*IN_WIDTH-1:0]                 twd_01_diff_re,
    input  logic [16*IN_WIDTH-1:0]                 twd_01_diff_im,
    input  logic                                   shift_02_valid,
    output logic [16*OUT_WIDTH-1:0]                stg02_sum_re,
    output logic [16*OUT_WIDTH-1:0]                stg02_sum_im,
    output logic [16*OUT_WIDTH-1:0]                stg02_diff_re,
    output logic [16*OUT_WIDTH-1:0]                stg02_diff_im,
    output logic                                   shift_03_valid,
    output logic                                   frame_start,
    output logic                                   frame_end,
    output logic                                   sat_beat,
    output logic [$clog2(BEATS_PER_FRAME+1)-1:0]   frame_sat_cnt
);

    // Width after rounding: one guard bit for the rounding add, minus dropped LSBs.
    localparam int RW    = IN_WIDTH + 1 - FRAC_DROP;
    localparam int IDX_W = (BEATS_PER_FRAME > 1) ? $clog2(BEATS_PER_FRAME) : 1;
    localparam int CNT_W = $clog2(BEATS_PER_FRAME + 1);

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BEATS_PER_FRAME - 1);
    localparam logic [IN_WIDTH:0] HALF     = (IN_WIDTH + 1)'(1) << (FRAC_DROP - 1);

    // Add half an output LSB at IN_WIDTH+1 bits (no wrap), then arithmetic
    // shift: round half toward +infinity.
    function automatic logic [RW-1:0] round_word(input logic [IN_WIDTH-1:0] x);
        logic signed [IN_WIDTH:0] r;
        r = $signed({x[IN_WIDTH-1], x} + HALF);
        return RW'(r >>> FRAC_DROP);
    endfunction

    // Returns {clip, value}. The value fits when every bit from the MSB down
    // to the output sign bit agrees.
    function automatic logic [OUT_WIDTH:0] sat_word(input logic [RW-1:0] v);
        logic [RW-OUT_WIDTH:0] top;
        top = v[RW-1:OUT_WIDTH-1];
        if ((top == '0) || (top == '1)) begin
            return {1'b0, v[OUT_WIDTH-1:0]};
        end else if (v[RW-1]) begin
            return {1'b1, 1'b1, {(OUT_WIDTH-1){1'b0}}};
        end else begin
            return {1'b1, 1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
    endfunction

    logic [16*IN_WIDTH-1:0]  in_ch [4];
    logic [16*RW-1:0]        rnd_p1_d [4];
    logic [16*RW-1:0]        rnd_p1_q [4];
    logic [16*OUT_WIDTH-1:0] sat_p2_d [4];
    logic [16*OUT_WIDTH-1:0] sat_p2_q [4];

    logic             vld_p1_q, vld_p2_q;
    logic [IDX_W-1:0] idx_p1_d, idx_p1_q;
    logic [IDX_W-1:0] idx_p2_d, idx_p2_q;
    logic             clip_p2_d, clip_p2_q;
    logic [IDX_W-1:0] beat_cnt_d, beat_cnt_q;
    logic [CNT_W-1:0] acc_d, acc_q;
    logic [CNT_W-1:0] frame_sat_cnt_d, frame_sat_cnt_q;

    assign in_ch[0] = twd_01_sum_re;
    assign in_ch[1] = twd_01_sum_im;
    assign in_ch[2] = twd_01_diff_re;
    assign in_ch[3] = twd_01_diff_im;

    // Beat counter: index of the beat currently on the input.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (shift_02_valid) begin
            beat_cnt_d = (beat_cnt_q == LAST_IDX) ? '0 : beat_cnt_q + 1'b1;
        end
    end

    // ---- stage A (p1): round ----
    always_comb begin
        idx_p1_d = shift_02_valid ? beat_cnt_q : idx_p1_q;
        for (int c = 0; c < 4; c++) begin
            rnd_p1_d[c] = rnd_p1_q[c];
            if (shift_02_valid) begin
                for (int l = 0; l < 16; l++) begin
                    rnd_p1_d[c][l*RW +: RW] = round_word(in_ch[c][l*IN_WIDTH +: IN_WIDTH]);
                end
            end
        end
    end

    // ---- stage B (p2): saturate ----
    always_comb begin
        logic [OUT_WIDTH:0] sw;
        logic               any_clip;
        sw        = '0;
        any_clip  = 1'b0;
        idx_p2_d  = vld_p1_q ? idx_p1_q : idx_p2_q;
        for (int c = 0; c < 4; c++) begin
            sat_p2_d[c] = sat_p2_q[c];
            for (int l = 0; l < 16; l++) begin
                sw = sat_word(rnd_p1_q[c][l*RW +: RW]);
                any_clip = any_clip | sw[OUT_WIDTH];
                if (vld_p1_q) begin
                    sat_p2_d[c][l*OUT_WIDTH +: OUT_WIDTH] = sw[OUT_WIDTH-1:0];
                end
            end
        end
        clip_p2_d = vld_p1_q ? any_clip : clip_p2_q;
    end

    // ---- output beat: framing and saturation statistics ----
    assign frame_start = vld_p2_q && (idx_p2_q == '0);
    assign frame_end   = vld_p2_q && (idx_p2_q == LAST_IDX);
    assign sat_beat    = vld_p2_q && clip_p2_q;

    always_comb begin
        acc_d           = acc_q;
        frame_sat_cnt_d = frame_sat_cnt_q;
        if (vld_p2_q) begin
            acc_d = frame_start ? CNT_W'(clip_p2_q) : acc_q + CNT_W'(clip_p2_q);
            // Publish the total including this last beat.
            if (frame_end) begin
                frame_sat_cnt_d = acc_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p1_q        <= 1'b0;
            vld_p2_q        <= 1'b0;
            idx_p1_q        <= '0;
            idx_p2_q        <= '0;
            clip_p2_q       <= 1'b0;
            beat_cnt_q      <= '0;
            acc_q           <= '0;
            frame_sat_cnt_q <= '0;
            for (int c = 0; c < 4; c++) begin
                rnd_p1_q[c] <= '0;
                sat_p2_q[c] <= '0;
            end
        end else begin
            vld_p1_q        <= shift_02_valid;
            vld_p2_q        <= vld_p1_q;
            idx_p1_q        <= idx_p1_d;
            idx_p2_q        <= idx_p2_d;
            clip_p2_q       <= clip_p2_d;
            beat_cnt_q      <= beat_cnt_d;
            acc_q           <= acc_d;
            frame_sat_cnt_q <= frame_sat_cnt_d;
            for (int c = 0; c < 4; c++) begin
                rnd_p1_q[c] <= rnd_p1_d[c];
                sat_p2_q[c] <= sat_p2_d[c];
            end
        end
    end

    assign stg02_sum_re   = sat_p2_q[0];
    assign stg02_sum_im   = sat_p2_q[1];
    assign stg02_diff_re  = sat_p2_q[2];
    assign stg02_diff_im  = sat_p2_q[3];
    assign shift_03_valid = vld_p2_q;
    assign frame_sat_cnt  = frame_sat_cnt_q;

endmodule
